// File: rtl/store_pkg.sv
// Shared constants for the result-store path: FSM encoding, default widths
// and the default start address of the store region in W_B_I_Buffer.
package store_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_IN_WIDTH   = 256;
  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int BEATS              = DEFAULT_IN_WIDTH / DEFAULT_WORD_WIDTH;

  // 112 fetch words of 8 beats each sit below the store region.
  localparam int DEFAULT_STORE_START_OFFSET = 112 * BEATS;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one wide input word and hands it out one Port A beat per cycle,
// least-significant slice first.
module word_serializer
  import store_pkg::*;
#(
  parameter int IN_WIDTH   = DEFAULT_IN_WIDTH,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IN_WIDTH-1:0]   load_data,
  output logic                  full,
  output logic                  last_beat,
  output logic [WORD_WIDTH-1:0] beat_data
);

  localparam int NUM_BEATS = IN_WIDTH / WORD_WIDTH;
  localparam int BEAT_W    = cnt_width(NUM_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  logic [IN_WIDTH-1:0] buf_reg;
  logic                full_reg;
  logic [BEAT_W-1:0]   beat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg  <= '0;
      full_reg <= 1'b0;
      beat_reg <= '0;
    end else if (load) begin
      // Load is only offered when empty or on the final beat, so nothing is lost.
      buf_reg  <= load_data;
      full_reg <= 1'b1;
      beat_reg <= '0;
    end else if (full_reg) begin
      buf_reg <= buf_reg >> WORD_WIDTH;
      if (beat_reg == LAST_BEAT) begin
        full_reg <= 1'b0;
        beat_reg <= '0;
      end else begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign full      = full_reg;
  assign last_beat = full_reg && (beat_reg == LAST_BEAT);
  assign beat_data = buf_reg[WORD_WIDTH-1:0];

endmodule

// File: rtl/store_logic_gen.sv
// Accepts wide result words and writes them as consecutive 32-bit beats to
// Port A of W_B_I_Buffer, pulsing store_done once a whole tile is written.
module store_logic_gen
  import store_pkg::*;
#(
  parameter int NUM_STORES_PER_TILE = 32,
  parameter int ADDR_WIDTH          = 14,
  parameter int STORE_START_OFFSET  = DEFAULT_STORE_START_OFFSET,
  parameter int IN_WIDTH            = DEFAULT_IN_WIDTH,
  parameter int WORD_WIDTH          = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [WORD_WIDTH-1:0] bram_dina,
  output logic                  store_done,
  output logic                  busy
);

  localparam int WORD_W = cnt_width(NUM_STORES_PER_TILE);
  localparam logic [WORD_W-1:0]     LAST_WORD  = WORD_W'(NUM_STORES_PER_TILE - 1);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(STORE_START_OFFSET);

  logic [1:0]            state_reg;
  logic [WORD_W-1:0]     word_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  full;
  logic                  last_beat;
  logic                  xfer;

  word_serializer #(
    .IN_WIDTH   (IN_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (in_data),
    .full      (full),
    .last_beat (last_beat),
    .beat_data (bram_dina)
  );

  // Ready depends on registered state only; the next word may be taken on the
  // final beat of the current one so a steady stream never leaves a write gap.
  assign in_ready = (state_reg == ST_RUN) &&
                    (!full || (last_beat && (word_reg != LAST_WORD)));
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      word_reg  <= '0;
      addr_reg  <= START_ADDR;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (reset_addr_counter) addr_reg <= START_ADDR;
          if (start_store) begin
            state_reg <= ST_RUN;
            word_reg  <= '0;
          end
        end
        ST_RUN: begin
          if (full) begin
            addr_reg <= addr_reg + 1'b1;
            if (last_beat) begin
              if (word_reg == LAST_WORD) begin
                state_reg <= ST_DONE;
                word_reg  <= '0;
              end else begin
                word_reg <= word_reg + 1'b1;
              end
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bram_ena   = full;
  assign bram_wea   = full;
  assign bram_addra = addr_reg;
  assign store_done = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_store_logic_gen.sv
// Randomized bench for store_logic_gen against a queue-based model of the
// Port A write stream, tile boundaries and address-counter behaviour.
module tb_store_logic_gen;

  localparam int NUM    = 32;
  localparam int AW     = 14;
  localparam int OFFSET = 896;
  localparam int INW    = 256;
  localparam int WW     = 32;
  localparam int AMASK  = (1 << AW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_store = 1'b0;
  logic           reset_addr_counter = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [INW-1:0] in_data = '0;
  logic           bram_ena;
  logic           bram_wea;
  logic [AW-1:0]  bram_addra;
  logic [WW-1:0]  bram_dina;
  logic           store_done;
  logic           busy;

  store_logic_gen #(
    .NUM_STORES_PER_TILE (NUM),
    .ADDR_WIDTH          (AW),
    .STORE_START_OFFSET  (OFFSET),
    .IN_WIDTH            (INW),
    .WORD_WIDTH          (WW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_store        (start_store),
    .reset_addr_counter (reset_addr_counter),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .bram_ena           (bram_ena),
    .bram_wea           (bram_wea),
    .bram_addra         (bram_addra),
    .bram_dina          (bram_dina),
    .store_done         (store_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 running, 2 done; queue holds beats still to write.
  int          phase;
  int          words_acc;
  int          m_addr;
  int          q_addr[$];
  logic [31:0] q_data[$];
  int          first_addr, tile_writes, gap_cycles, word4_addr, prev_pop;
  bit          saw_wrap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return (phase == 1) &&
           ((q_addr.size() == 0) || (q_addr.size() == 1 && words_acc < NUM));
  endfunction

  task automatic model_reset();
    phase = 0;
    words_acc = 0;
    m_addr = OFFSET;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic check_cycle();
    bit wr;
    wr = (q_addr.size() != 0);
    check_eq("in_ready", in_ready, model_ready());
    check_eq("busy", busy, phase != 0);
    check_eq("store_done", store_done, phase == 2);
    check_eq("bram_wea", bram_wea, wr);
    check_eq("bram_ena", bram_ena, wr);
    check_eq("bram_addra", bram_addra, m_addr);
    if (wr) check_eq("bram_dina", bram_dina, q_data[0]);
  endtask

  task automatic model_edge();
    bit rdy, had_beat;
    int base;
    rdy = model_ready();
    had_beat = (q_addr.size() != 0);
    case (phase)
      0: begin
        if (reset_addr_counter) m_addr = OFFSET;
        if (start_store) begin
          phase = 1;
          words_acc = 0;
        end
      end
      2: phase = 0;
      default: begin
        if (in_valid && rdy) begin
          base = m_addr + q_addr.size();
          if (words_acc == 4) word4_addr = base & AMASK;
          for (int i = 0; i < 8; i++) begin
            q_addr.push_back((base + i) & AMASK);
            q_data.push_back(in_data[32*i +: 32]);
          end
          words_acc++;
        end
        if (had_beat) begin
          if (first_addr < 0) first_addr = q_addr[0];
          if (prev_pop == AMASK && q_addr[0] == 0) saw_wrap = 1;
          prev_pop = q_addr[0];
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          m_addr = (m_addr + 1) & AMASK;
          tile_writes++;
          if (q_addr.size() == 0 && words_acc == NUM) phase = 2;
        end
      end
    endcase
  endtask

  task automatic tick();
    if (phase == 1 && first_addr >= 0 && q_addr.size() == 0) gap_cycles++;
    check_cycle();
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) in_data[32*i +: 32] = $urandom;
  endtask

  // mode 0: valid held high, 1: random valid, 2: valid high with a 5-cycle hole after word 3.
  // pre: 0 none, 1 reload with start, 2 reload one idle cycle before start.
  task automatic run_tile(input int mode, input int pre, input int exp_start,
                          input bit pattern, input bit abort);
    int n, gap_left;
    bit gap_armed, aborted;
    first_addr = -1; tile_writes = 0; gap_cycles = 0; word4_addr = -1;
    gap_left = 0; gap_armed = 0; aborted = 0;
    if (pre == 2) begin
      reset_addr_counter = 1'b1;
      tick();
      reset_addr_counter = 1'b0;
    end
    start_store = 1'b1;
    reset_addr_counter = (pre == 1);
    in_valid = 1'b0;
    tick();
    start_store = 1'b0;
    reset_addr_counter = 1'b0;
    n = 0;
    while (phase != 0 && n < 3000) begin
      rand_data();
      if (pattern && words_acc == 0)
        for (int i = 0; i < 8; i++) in_data[32*i +: 32] = i;
      if (mode == 2 && words_acc == 4 && !gap_armed) begin
        gap_armed = 1;
        gap_left = 5;
      end
      case (mode)
        0, 2:    in_valid = (gap_left == 0);
        default: in_valid = ($urandom_range(3, 0) != 0);
      endcase
      if (gap_left > 0 && model_ready()) gap_left--;
      start_store        = ($urandom_range(15, 0) == 0);
      reset_addr_counter = ($urandom_range(15, 0) == 0);
      if (abort && words_acc == 11 && q_addr.size() == 4) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("abort_done", store_done, 0);
        check_eq("abort_ena", bram_ena, 0);
        check_eq("abort_wea", bram_wea, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", in_ready, 0);
        check_eq("abort_addra", bram_addra, OFFSET);
        check_eq("abort_dina", bram_dina, 0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
      end else begin
        tick();
      end
      n++;
    end
    start_store = 1'b0;
    reset_addr_counter = 1'b0;
    in_valid = 1'b0;
    check_eq("tile_finished", phase == 0, 1);
    if (abort) begin
      check_eq("abort_hit", aborted, 1);
      repeat (6) tick();
    end else begin
      check_eq("tile_writes", tile_writes, 8 * NUM);
      if (exp_start >= 0) check_eq("tile_start", first_addr, exp_start);
      if (mode == 0) check_eq("tile_gap", gap_cycles, 0);
      if (mode == 2) begin
        check_eq("tile_gap", gap_cycles, 5);
        check_eq("resume_addr", word4_addr, (first_addr + 32) & AMASK);
      end
    end
    $display("tile mode=%0d start=%0d writes=%0d gap=%0d next_addr=%0d",
             mode, first_addr, tile_writes, gap_cycles, m_addr);
  endtask

  initial begin
    int t;
    model_reset();
    prev_pop = -1;
    saw_wrap = 0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_ena", bram_ena, 0);
    check_eq("rst_wea", bram_wea, 0);
    check_eq("rst_done", store_done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dina", bram_dina, 0);
    check_eq("rst_addra", bram_addra, OFFSET);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    run_tile(0, 0, 896, 1'b1, 1'b0);
    run_tile(1, 0, 1152, 1'b0, 1'b0);
    run_tile(2, 2, 896, 1'b0, 1'b0);
    run_tile(1, 1, 896, 1'b0, 1'b0);

    t = 0;
    while (!saw_wrap && t < 70) begin
      run_tile(1, 0, -1, 1'b0, 1'b0);
      t++;
    end
    check_eq("addr_wrap", saw_wrap, 1);

    run_tile(0, 0, -1, 1'b0, 1'b1);
    run_tile(0, 0, 896, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
